// File: rtl/arb_pkg.sv
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared constants and state encoding for the memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin priority encoder (search from ptr+1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] idx;

  // Scan farthest-to-nearest so the nearest set bit after ptr is the final write.
  always_comb begin
    valid = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : 4-way round-robin arbiter for a shared 32-bit resource port.
//           Optional forced release on stuck grants via macro ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout_err
);

  state_t           state, state_next;
  logic [SEL_W-1:0] ptr, ptr_next, sel_next;
  logic [N_REQ-1:0] grant_next;
  logic             busy_next;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_win;
  logic             force_rel;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .win   (pick_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= PTR_RST;
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      grant <= grant_next;
      sel   <= sel_next;
      busy  <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant;
    sel_next   = sel;
    busy_next  = busy;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          grant_next = N_REQ'(1) << pick_win;
          sel_next   = pick_win;
          busy_next  = 1'b1;
          ptr_next   = pick_win;
        end
      end
      GRANT: begin
        // A forced release behaves exactly like done, including re-arbitration.
        if (done || force_rel) begin
          if (pick_valid) begin
            grant_next = N_REQ'(1) << pick_win;
            sel_next   = pick_win;
            ptr_next   = pick_win;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            busy_next  = 1'b0;
          end
        end else if (!req[sel]) begin
          state_next = IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             new_grant;

  assign force_rel = (state == GRANT) && !done &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign new_grant = (state_next == GRANT) &&
                     ((state == IDLE) || done || force_rel);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= force_rel;
      if (new_grant || state_next == IDLE)
        tmo_cnt <= '0;
      else if (state == GRANT && !done)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign force_rel   = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_tmo  = ^{TIMEOUT_CYCLES, TMO_W};
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  int vectors = 0;
  int errors  = 0;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (8),
    .TMO_W          (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".sel"},   32'(sel),   32'(s));
    check({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  logic [3:0] rot [4];

  initial begin
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    tick(); tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0);
    check("reset.terr", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    // Single request, one-cycle latency, then done with req drop.
    req = 4'b0001;
    tick();
    check_out("single", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000; done = 1'b1;
    tick();
    check_out("single_done", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;

    // All requesting; ptr=0 so rotation starts at requester 1.
    req = 4'b1111;
    tick();
    check_out("rot_first", 4'b0010, 2'd1, 1'b1);
    rot[0] = 4'b0100; rot[1] = 4'b1000; rot[2] = 4'b0001; rot[3] = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rot_hold.busy", 32'(busy), 32'd1);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rot.grant", 32'(grant), 32'(rot[k]));
      check("rot.busy", 32'(busy), 32'd1);
    end
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    check_out("rot_end", 4'b0000, 2'd1, 1'b0);

    // ptr=1, req=1011 -> 3, then 0, then 1.
    req = 4'b1011;
    tick();
    check_out("ptr1_w3", 4'b1000, 2'd3, 1'b1);
    req = 4'b0011; done = 1'b1;
    tick();
    check_out("ptr3_w0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0010;
    tick();
    check_out("ptr0_w1", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick();
    done = 1'b0;
    check_out("ptr_end", 4'b0000, 2'd1, 1'b0);

    // Abort: granted requester 2 drops req without done; done in IDLE ignored.
    req = 4'b0100;
    tick();
    check_out("abort_grant", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    tick();
    check_out("abort", 4'b0000, 2'd2, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("idle_done", 4'b0000, 2'd2, 1'b0);

    // Reset mid-transaction; ptr returns to 3 so requester 0 beats 3.
    req = 4'b0100;
    tick();
    check_out("pre_rst", 4'b0100, 2'd2, 1'b1);
    rst = 1'b1;
    tick();
    check_out("mid_rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0; req = 4'b1001;
    tick();
    check_out("post_rst", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    check_out("post_rst_end", 4'b0000, 2'd0, 1'b0);

    // Fairness: requester 1 keeps requesting past its done; 0 goes first.
    req = 4'b0011;
    tick();
    check_out("fair_1", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    tick();
    check_out("fair_0", 4'b0001, 2'd0, 1'b1);
    req = 4'b0010;
    tick();
    check_out("fair_1b", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick();
    done = 1'b0;
    check_out("fair_end", 4'b0000, 2'd1, 1'b0);

    // Stuck grant with no done.
    req = 4'b0010;
    tick();
    check_out("stuck_grant", 4'b0010, 2'd1, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 7; k++) begin
      tick();
      check("tmo_pre.terr", 32'(timeout_err), 32'd0);
    end
    tick();
    check("tmo_pulse.terr", 32'(timeout_err), 32'd1);
    check_out("tmo_regrant", 4'b0010, 2'd1, 1'b1);
    tick();
    check("tmo_post.terr", 32'(timeout_err), 32'd0);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      check("hold.terr", 32'(timeout_err), 32'd0);
    end
    check_out("hold_100", 4'b0010, 2'd1, 1'b1);
`endif
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    check_out("final", 4'b0000, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
